ps2_rx_fifo: RTL
================

# ps2_rx_fifo

Parametrised PS/2 keyboard receiver and the next generation of our single-frame PS/2 receiver. It replaces the one-shot `pulso_done` strobe with a small FIFO and a valid/ready handshake. It adds a configurable glitch filter, odd-parity and stop-bit checking, a frame watchdog, and optional E0/F0 prefix folding. It sits between the PS/2 pins and the scan-code consumer (display/command logic).

## Interface
- `FILTER_LEN`, 8: ps2_clk glitch-filter length in clk cycles; even, ≥4.
- `TIMEOUT`, 100000: clk cycles allowed between two falling edges inside a frame.
- `FIFO_DEPTH`, 4: scan-code FIFO entries; power of two, ≥2.
- `DECODE_PREFIX`, 1: 1 folds E0/F0 into flags; 0 passes every byte raw.
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ps2_clk`  in  1  PS/2 clock pin, asynchronous.
- `ps2_data`  in  1  PS/2 data pin, asynchronous.
- `rx_data`  out  8  FIFO head scan code.
- `rx_ext`  out  1  head entry was preceded by E0.
- `rx_break`  out  1  head entry was preceded by F0 (key release).
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer accepts head; pop when `rx_valid && rx_ready`.
- `err_parity`  out  1  one-cycle pulse: parity error.
- `err_frame`  out  1  one-cycle pulse: stop bit was 0.
- `err_timeout`  out  1  one-cycle pulse: frame aborted by the watchdog.
- `overflow`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.

## Operation
- **Input path**
  - `ps2_clk` and `ps2_data` each pass through a 2-flop synchroniser.
  - Synchronised `ps2_clk` shifts into a FILTER_LEN-bit register, newest sample in the MSB.
  - `fall` pulses for one cycle when the newest FILTER_LEN/2 samples are 0 and the oldest FILTER_LEN/2 are 1.
  - Data is sampled from synchronised `ps2_data` in the `fall` cycle.
- **Frame FSM**
  - IDLE: on `fall` with data=0 (start bit), go to DATA with bit_cnt=0. On `fall` with data=1, stay in IDLE silently.
  - DATA: on each `fall`, shreg <= {d, shreg[7:1]} (LSB first) and bit_cnt++. The 8th bit moves to PARITY.
  - PARITY: on `fall`, capture p and move to STOP.
  - STOP: on `fall`, evaluate and return to IDLE.
    - Parity is good when XOR(shreg, p) = 1.
    - If parity is bad, pulse `err_parity`.
    - Else if stop=0, pulse `err_frame`.
    - Else the byte is good.
    - Parity error takes priority; only one error pulses per frame.
- **Watchdog**
  - The counter clears on every `fall` and counts while not in IDLE.
  - When it reaches TIMEOUT-1: go to IDLE, discard the partial byte, pulse `err_timeout`.
- **Prefix folding** (DECODE_PREFIX=1)
  - A good E0 sets ext_pend; a good F0 sets brk_pend. Neither is pushed.
  - Any other good byte is pushed with {ext_pend, brk_pend}, then both clear.
  - Any error pulse also clears both.
  - With DECODE_PREFIX=0, every good byte is pushed with both flags 0.
- **FIFO** (first-word fall-through)
  - `rx_data`, `rx_ext`, `rx_break` show the head entry whenever `rx_valid`=1.
  - Push when full and no pop: drop the byte and pulse `overflow`.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Pointers wrap modulo FIFO_DEPTH. An occupancy counter of width log2(FIFO_DEPTH)+1 distinguishes full from empty.
- **Reset** (asynchronous, `reset_n`=0)
  - FSM goes to IDLE; bit_cnt, watchdog, pointers and count clear; pending flags clear.
  - Synchroniser and filter registers are set to all 1 (idle line).
  - All outputs go to 0; `rx_data` is 0.
  - Reset mid-frame discards the frame with no error pulse.

## Timing
- A physical ps2_clk fall produces `fall` 2 + FILTER_LEN/2 cycles later.
- Stop-bit `fall` at cycle N:
  - Good/error decision is registered at N+1; error pulses are high during N+1 only.
  - FIFO write occurs at the end of N+1; `rx_valid` and head data are valid from N+2.
- Pop takes effect on the edge where `rx_valid && rx_ready`. The next head, or `rx_valid`=0, appears the following cycle.
- Throughput: one frame per 11 PS/2 clocks. The FIFO absorbs up to FIFO_DEPTH bytes of consumer stall.

## Test plan
- **Single byte:** frame 0x1C with p=0, stop=1, `rx_ready`=1 → one entry 0x1C with ext=0, brk=0; `rx_valid` high for exactly 1 cycle; no error pulses.
- **Prefix folding:** frames E0, F0, 0x74 → exactly one entry, 0x74 with ext=1, brk=1. Repeat with DECODE_PREFIX=0 → three entries E0, F0, 74, all flags 0.
- **Bad frames:** 0x1C with p=1 → `err_parity` 1-cycle pulse, FIFO unchanged. 0x1C with stop=0 → `err_frame` pulse only. F0 followed by a bad-parity byte, then 0x29 → 0x29 with brk=0.
- **Timeout recovery:** start bit plus 4 data bits, then idle TIMEOUT cycles → `err_timeout` pulse, FSM in IDLE. A following good 0x29 is received intact.
- **Overflow:** FIFO_DEPTH=4, `rx_ready`=0, frames 11, 22, 33, 44, 55 → `overflow` on 55. Then `rx_ready`=1 → reads 11, 22, 33, 44 in order, then `rx_valid`=0.
- **Glitch and reset:** a 2-cycle low glitch on `ps2_clk` → no bit counted. Assert `reset_n` after bit 5 → all outputs 0. The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronised and glitch-filtered ps2_clk, frame FSM with
// parity/stop/watchdog checking, optional E0/F0 prefix folding, and a fall-through FIFO.
module ps2_rx_fifo #(
    parameter int FILTER_LEN    = 8,
    parameter int TIMEOUT       = 100000,
    parameter int FIFO_DEPTH    = 4,
    parameter int DECODE_PREFIX = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_ext,
    output logic       rx_break,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_timeout,
    output logic       overflow
);

    localparam int HALF = FILTER_LEN / 2;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WDW  = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LAST   = WDW'(TIMEOUT - 1);
    localparam logic [AW:0]    FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BREAK = 8'hF0;

    // ------------------------------------------------------------------
    // Input synchronisers and ps2_clk glitch filter (idle line is high)
    // ------------------------------------------------------------------
    logic [1:0]            clk_sync_reg;
    logic [1:0]            data_sync_reg;
    logic [FILTER_LEN-1:0] filt_reg;
    logic                  clk_s;
    logic                  data_s;
    logic                  fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_reg  <= 2'b11;
            data_sync_reg <= 2'b11;
            filt_reg      <= '1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
            data_sync_reg <= {data_sync_reg[0], ps2_data};
            filt_reg      <= {clk_s, filt_reg[FILTER_LEN-1:1]};
        end
    end

    assign clk_s  = clk_sync_reg[1];
    assign data_s = data_sync_reg[1];

    // Newest half all low after an oldest half all high: exactly one cycle per clean edge.
    assign fall = (~|filt_reg[FILTER_LEN-1 -: HALF]) && (&filt_reg[HALF-1:0]);

    // ------------------------------------------------------------------
    // Frame FSM and watchdog
    // ------------------------------------------------------------------
    logic [1:0]     state_reg,   state_next;
    logic [2:0]     bit_cnt_reg, bit_cnt_next;
    logic [7:0]     shreg_reg,   shreg_next;
    logic           par_reg,     par_next;
    logic [WDW-1:0] wd_reg,      wd_next;
    logic           good_reg,    good_next;
    logic           perr_reg,    perr_next;
    logic           ferr_reg,    ferr_next;
    logic           terr_reg,    terr_next;

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        par_next     = par_reg;
        wd_next      = wd_reg;
        good_next    = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;
        terr_next    = 1'b0;

        if (fall) begin
            wd_next = '0;
            case (state_reg)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_next   = ST_DATA;
                        bit_cnt_next = 3'd0;
                    end
                end
                ST_DATA: begin
                    shreg_next   = {data_s, shreg_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_next   = data_s;
                    state_next = ST_STOP;
                end
                default: begin
                    state_next   = ST_IDLE;
                    bit_cnt_next = 3'd0;
                    // Odd parity over data+parity; parity failure masks a bad stop bit.
                    if (!(^shreg_reg ^ par_reg)) begin
                        perr_next = 1'b1;
                    end else if (!data_s) begin
                        ferr_next = 1'b1;
                    end else begin
                        good_next = 1'b1;
                    end
                end
            endcase
        end else if (state_reg != ST_IDLE) begin
            if (wd_reg == WD_LAST) begin
                state_next   = ST_IDLE;
                bit_cnt_next = 3'd0;
                wd_next      = '0;
                terr_next    = 1'b1;
            end else begin
                wd_next = wd_reg + WDW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 3'd0;
            shreg_reg   <= 8'd0;
            par_reg     <= 1'b0;
            wd_reg      <= '0;
            good_reg    <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
            terr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
            par_reg     <= par_next;
            wd_reg      <= wd_next;
            good_reg    <= good_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
            terr_reg    <= terr_next;
        end
    end

    assign err_parity  = perr_reg;
    assign err_frame   = ferr_reg;
    assign err_timeout = terr_reg;

    // ------------------------------------------------------------------
    // Prefix folding: decides what (if anything) gets pushed.
    // shreg_reg is stable in the cycle after the stop bit, so it is the byte.
    // ------------------------------------------------------------------
    logic       push;
    logic [1:0] push_flags;
    logic       any_err;

    assign any_err = perr_reg | ferr_reg | terr_reg;

    generate
        if (DECODE_PREFIX != 0) begin : g_fold
            logic ext_pend_reg;
            logic brk_pend_reg;
            logic is_ext;
            logic is_brk;

            assign is_ext     = (shreg_reg == CODE_EXT);
            assign is_brk     = (shreg_reg == CODE_BREAK);
            assign push       = good_reg && !is_ext && !is_brk;
            assign push_flags = {ext_pend_reg, brk_pend_reg};

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    ext_pend_reg <= 1'b0;
                    brk_pend_reg <= 1'b0;
                end else if (any_err || push) begin
                    ext_pend_reg <= 1'b0;
                    brk_pend_reg <= 1'b0;
                end else if (good_reg) begin
                    if (is_ext) ext_pend_reg <= 1'b1;
                    if (is_brk) brk_pend_reg <= 1'b1;
                end
            end
        end else begin : g_raw
            assign push       = good_reg;
            assign push_flags = 2'b00;
        end
    endgenerate

    // ------------------------------------------------------------------
    // First-word fall-through FIFO of {ext, break, code}
    // ------------------------------------------------------------------
    logic [9:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          ovf_reg;
    logic          full;
    logic          pop;
    logic          do_write;
    logic [9:0]    head;

    assign full     = (count_reg == FIFO_FULL);
    assign pop      = rx_valid && rx_ready;
    assign do_write = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_reg] <= {push_flags, shreg_reg};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            ovf_reg <= push && full && !pop;
            if (do_write) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)      rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_write, pop})
                2'b10:   count_reg <= count_reg + (AW + 1)'(1);
                2'b01:   count_reg <= count_reg - (AW + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Outputs are forced to 0 while empty so reset and idle present a clean bus.
    assign head     = mem[rd_ptr_reg];
    assign rx_valid = (count_reg != '0);
    assign rx_data  = rx_valid ? head[7:0] : 8'd0;
    assign rx_break = rx_valid & head[8];
    assign rx_ext   = rx_valid & head[9];
    assign overflow = ovf_reg;

endmodule
